regbank_write_scheduler: RTL and testbench
==========================================

Name: regbank_write_scheduler

Overview:
- Owns the single write port of the 32x64 general register bank.
- Arbitrates between two writeback requesters, the ALU and the memory-load path, with round-robin fairness.
- Registers the winning write onto the bank port.
- Keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards on the bank's two read ports.

Parameters:
- DATA_WIDTH, 64, width of write data.
- ADDR_WIDTH, 5, register address width; scoreboard has 2**ADDR_WIDTH bits.

Ports:
- clock  input  1  rising-edge clock (named as elsewhere in the codebase).
- reset_n  input  1  asynchronous active-low reset.
- hold  input  1  pipeline freeze; blocks all acceptance.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle.
- alu_address  input  ADDR_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- mem_valid  input  1  load writeback request.
- mem_ready  output  1  load request accepted this cycle.
- mem_address  input  ADDR_WIDTH  load destination register.
- mem_data  input  DATA_WIDTH  load data.
- reserve_valid  input  1  decode issued an instruction with a destination.
- reserve_address  input  ADDR_WIDTH  destination to mark pending.
- read_address_1  input  ADDR_WIDTH  bank read port 1 address.
- read_address_2  input  ADDR_WIDTH  bank read port 2 address.
- hazard_1  output  1  read_address_1 has a pending write.
- hazard_2  output  1  read_address_2 has a pending write.
- write  output  1  bank write enable.
- write_address  output  ADDR_WIDTH  bank write address.
- write_data  output  DATA_WIDTH  bank write data.
- busy_mask  output  2**ADDR_WIDTH  scoreboard contents.

Behaviour:
- Reset is asynchronous on reset_n low.
  - write=0, write_address=0, write_data=0, busy_mask=0.
  - Round-robin flag favours the ALU.
  - A request already accepted but not yet driven is discarded; this is legal mid-operation.
- Arbitration is combinational and has no bubbles.
  - hold=1: alu_ready=0 and mem_ready=0.
  - Only one requester valid: that requester is ready.
  - Both valid: the requester favoured by the flag is ready; the other sees ready=0 and must keep valid, address and data stable.
  - At most one ready per cycle.
  - A request is accepted when valid && ready is true at a rising edge.
- Round-robin update happens on every acceptance. After an ALU accept the flag favours MEM; after a MEM accept it favours the ALU. No acceptance leaves the flag unchanged.
- Output stage has 1-cycle latency.
  - On an accepting edge, write_address and write_data load the winner's fields and write becomes 1.
  - On any edge without acceptance, write becomes 0 and address/data hold their values.
  - Sustained throughput is one write per cycle.
  - hold does not squash a write already registered.
- Scoreboard, evaluated per edge:
  - reserve_valid sets busy[reserve_address].
  - write=1 clears busy[write_address]. This is the same edge at which the bank captures the data.
  - Same address set and cleared in one edge: set wins, because a new producer is in flight.
  - Reserving an already-busy register leaves it busy; there is no count.
  - A write to a non-busy register is legal, and clearing it is a no-op.
- Hazards are combinational: hazard_n = busy[read_address_n]. No forwarding is done here.
- Register 31 gets no special handling; address 31 arbitrates and scoreboards like any other.

Test Plan:
- Reset then idle: reset_n=0 mid-run → write=0, busy_mask=0 immediately, with no clock needed; after release, alu_valid=1 addr 3 data 0x11 → alu_ready=1 same cycle, write=1 addr 3 data 0x11 next cycle for exactly one cycle.
- Contention fairness: alu_valid and mem_valid held 1 for 4 accepts, ALU addr 1, MEM addr 2 → grants ALU, MEM, ALU, MEM; write_address sequence 1,2,1,2 on consecutive cycles.
- Scoreboard lifecycle:
  - reserve_valid addr 5 → busy_mask bit5=1, and hazard_1=1 with read_address_1=5.
  - ALU writes addr 5 two cycles later → bit5 clears on the edge where write=1; hazard_1=0 in the following cycle.
- Set/clear collision: write=1 to addr 7 while reserve_valid addr 7 on the same edge → bit7 remains 1.
- Hold: hold=1 with both valid for 3 cycles → both ready=0 and write=0 after the in-flight write drains; hold=0 → ALU granted first when the flag favours it.
- Back-to-back single requester: mem_valid=1 for 3 cycles with addresses 8,9,10 → mem_ready=1 each cycle; write=1 for 3 consecutive cycles with addresses 8,9,10.

Source files
------------

// File: rtl/regbank_write_scheduler.sv
// Write-port scheduler for the general register bank: round-robin ALU/load arbitration,
// a registered bank write port, and a pending-write scoreboard for read-after-write hazard detection.
module regbank_write_scheduler #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       hold,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [ADDR_WIDTH-1:0]      alu_address,
   input  logic [DATA_WIDTH-1:0]      alu_data,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [ADDR_WIDTH-1:0]      mem_address,
   input  logic [DATA_WIDTH-1:0]      mem_data,
   input  logic                       reserve_valid,
   input  logic [ADDR_WIDTH-1:0]      reserve_address,
   input  logic [ADDR_WIDTH-1:0]      read_address_1,
   input  logic [ADDR_WIDTH-1:0]      read_address_2,
   output logic                       hazard_1,
   output logic                       hazard_2,
   output logic                       write,
   output logic [ADDR_WIDTH-1:0]      write_address,
   output logic [DATA_WIDTH-1:0]      write_data,
   output logic [(2**ADDR_WIDTH)-1:0] busy_mask
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   logic                  r_favour_mem;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_write_address;
   logic [DATA_WIDTH-1:0] r_write_data;
   logic [NREG-1:0]       r_busy;

   logic                  w_alu_grant;
   logic                  w_mem_grant;
   logic                  w_accept;
   logic [ADDR_WIDTH-1:0] w_win_address;
   logic [DATA_WIDTH-1:0] w_win_data;
   logic [NREG-1:0]       w_busy_next;

   // Arbitration: a lone requester always wins; under contention the flag decides.
   assign w_alu_grant = ~hold & alu_valid & (~mem_valid | ~r_favour_mem);
   assign w_mem_grant = ~hold & mem_valid & (~alu_valid |  r_favour_mem);
   assign w_accept    = w_alu_grant | w_mem_grant;

   assign w_win_address = w_mem_grant ? mem_address : alu_address;
   assign w_win_data    = w_mem_grant ? mem_data    : alu_data;

   assign alu_ready = w_alu_grant;
   assign mem_ready = w_mem_grant;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_favour_mem <= 1'b0;
      end else if (w_accept) begin
         r_favour_mem <= w_alu_grant;
      end
   end

   // Output stage: one registered write per accepting edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_write         <= 1'b0;
         r_write_address <= '0;
         r_write_data    <= '0;
      end else begin
         r_write <= w_accept;
         if (w_accept) begin
            r_write_address <= w_win_address;
            r_write_data    <= w_win_data;
         end
      end
   end

   // The set is applied after the clear so a new producer keeps the register busy.
   always_comb begin
      w_busy_next = r_busy;
      if (r_write) begin
         w_busy_next[r_write_address] = 1'b0;
      end
      if (reserve_valid) begin
         w_busy_next[reserve_address] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   assign hazard_1      = r_busy[read_address_1];
   assign hazard_2      = r_busy[read_address_2];
   assign write         = r_write;
   assign write_address = r_write_address;
   assign write_data    = r_write_data;
   assign busy_mask     = r_busy;

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Bench for regbank_write_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model of the scheduler.
module tb_regbank_write_scheduler;

   localparam int DW   = 64;
   localparam int AW   = 5;
   localparam int NREG = 32;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          hold;
   logic          alu_valid;
   logic          alu_ready;
   logic [AW-1:0] alu_address;
   logic [DW-1:0] alu_data;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data;
   logic          reserve_valid;
   logic [AW-1:0] reserve_address;
   logic [AW-1:0] read_address_1;
   logic [AW-1:0] read_address_2;
   logic          hazard_1;
   logic          hazard_2;
   logic          write;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
   logic [NREG-1:0] busy_mask;

   int n_assert = 0;
   int n_fail   = 0;

   regbank_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .hold            (hold),
      .alu_valid       (alu_valid),
      .alu_ready       (alu_ready),
      .alu_address     (alu_address),
      .alu_data        (alu_data),
      .mem_valid       (mem_valid),
      .mem_ready       (mem_ready),
      .mem_address     (mem_address),
      .mem_data        (mem_data),
      .reserve_valid   (reserve_valid),
      .reserve_address (reserve_address),
      .read_address_1  (read_address_1),
      .read_address_2  (read_address_2),
      .hazard_1        (hazard_1),
      .hazard_2        (hazard_2),
      .write           (write),
      .write_address   (write_address),
      .write_data      (write_data),
      .busy_mask       (busy_mask)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: who wins, what the port shows, which registers await a write.
   logic            m_favour_mem;
   logic            m_write;
   logic [AW-1:0]   m_waddr;
   logic [DW-1:0]   m_wdata;
   logic [NREG-1:0] m_busy;

   // Returns {mem wins, alu wins}.
   function automatic logic [1:0] pick(input logic h, input logic av, input logic mv, input logic fm);
      if (h) return 2'b00;
      if (av && mv) return fm ? 2'b10 : 2'b01;
      return {mv, av};
   endfunction

   function automatic logic [NREG-1:0] next_busy(input logic [NREG-1:0] b, input logic wr,
                                                 input logic [AW-1:0] wa, input logic rv,
                                                 input logic [AW-1:0] ra);
      logic [NREG-1:0] n;
      n = b;
      if (wr) n[wa] = 1'b0;
      if (rv) n[ra] = 1'b1;
      return n;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_favour_mem <= 1'b0;
         m_write      <= 1'b0;
         m_waddr      <= '0;
         m_wdata      <= '0;
         m_busy       <= '0;
      end else begin
         m_busy <= next_busy(m_busy, m_write, m_waddr, reserve_valid, reserve_address);
         case (pick(hold, alu_valid, mem_valid, m_favour_mem))
            2'b01: begin
               m_write <= 1'b1; m_waddr <= alu_address; m_wdata <= alu_data; m_favour_mem <= 1'b1;
            end
            2'b10: begin
               m_write <= 1'b1; m_waddr <= mem_address; m_wdata <= mem_data; m_favour_mem <= 1'b0;
            end
            default: m_write <= 1'b0;
         endcase
      end
   end

   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         logic [1:0] g;
         g = pick(hold, alu_valid, mem_valid, m_favour_mem);
         chk("alu_ready", alu_ready, g[0]);
         chk("mem_ready", mem_ready, g[1]);
         chk("write", write, m_write);
         if (m_write) begin
            chk("write_address", write_address, m_waddr);
            chk("write_data", write_data, m_wdata);
         end
         chk("busy_mask", busy_mask, m_busy);
         chk("hazard_1", hazard_1, m_busy[read_address_1]);
         chk("hazard_2", hazard_2, m_busy[read_address_2]);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 9) == 0) return 5'd31;
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      logic a_acc;
      logic m_acc;
      reset_n = 1'b0; hold = 1'b0;
      alu_valid = 1'b0; alu_address = '0; alu_data = '0;
      mem_valid = 1'b0; mem_address = '0; mem_data = '0;
      reserve_valid = 1'b0; reserve_address = '0;
      read_address_1 = '0; read_address_2 = '0;
      #1;
      chk("reset_write", write, 0);
      chk("reset_busy", busy_mask, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // Contention: ALU and MEM alternate, starting with ALU.
      alu_valid = 1'b1; alu_address = 5'd1; alu_data = 64'hA1;
      mem_valid = 1'b1; mem_address = 5'd2; mem_data = 64'hB2;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_alu_ready", alu_ready, (i % 2 == 0));
         chk("rr_mem_ready", mem_ready, (i % 2 == 1));
         tick();
         chk("rr_write", write, 1);
         chk("rr_write_address", write_address, (i % 2 == 0) ? 5'd1 : 5'd2);
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
      chk("rr_idle_write", write, 0);

      // Scoreboard lifecycle on register 5.
      reserve_valid = 1'b1; reserve_address = 5'd5;
      read_address_1 = 5'd5; read_address_2 = 5'd5;
      tick();
      reserve_valid = 1'b0;
      #1;
      chk("sb_busy5_set", busy_mask[5], 1);
      chk("sb_hazard_1_set", hazard_1, 1);
      chk("sb_hazard_2_set", hazard_2, 1);
      tick();
      alu_valid = 1'b1; alu_address = 5'd5; alu_data = 64'h55;
      tick();
      alu_valid = 1'b0;
      chk("sb_write5", write, 1);
      chk("sb_busy5_before_clear", busy_mask[5], 1);
      tick();
      chk("sb_busy5_cleared", busy_mask[5], 0);
      chk("sb_hazard_1_clear", hazard_1, 0);

      // Set and clear of register 7 on the same edge: it stays busy.
      alu_valid = 1'b1; alu_address = 5'd7; alu_data = 64'h77;
      tick();
      alu_valid = 1'b0;
      reserve_valid = 1'b1; reserve_address = 5'd7;
      tick();
      reserve_valid = 1'b0;
      chk("collide_busy7", busy_mask[7], 1);

      // Hold: in-flight write drains, nothing accepted, ALU wins on release.
      mem_valid = 1'b1; mem_address = 5'd12; mem_data = 64'hC12;
      tick();
      hold = 1'b1;
      alu_valid = 1'b1; alu_address = 5'd13; alu_data = 64'hD13;
      mem_address = 5'd14; mem_data = 64'hE14;
      #1;
      chk("hold_alu_ready", alu_ready, 0);
      chk("hold_mem_ready", mem_ready, 0);
      chk("hold_inflight_write", write, 1);
      chk("hold_inflight_address", write_address, 12);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_write", write, 0);
      end
      hold = 1'b0;
      #1;
      chk("release_alu_ready", alu_ready, 1);
      chk("release_mem_ready", mem_ready, 0);
      tick();
      alu_valid = 1'b0;
      chk("release_write_address", write_address, 13);
      tick();
      mem_valid = 1'b0;
      chk("release_mem_write_address", write_address, 14);
      tick();

      // Back-to-back loads.
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1'b1; mem_address = 5'(8 + i); mem_data = 64'(100 + i);
         #1;
         chk("b2b_mem_ready", mem_ready, 1);
         tick();
         chk("b2b_write", write, 1);
         chk("b2b_write_address", write_address, 8 + i);
         chk("b2b_write_data", write_data, 100 + i);
      end
      mem_valid = 1'b0;
      tick();
      chk("b2b_idle_write", write, 0);

      // Randomized traffic; stalled requests keep their fields stable.
      a_acc = 1'b1; m_acc = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (!(alu_valid && !a_acc)) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_address = rnd_addr();
            alu_data = {$urandom, $urandom};
         end
         if (!(mem_valid && !m_acc)) begin
            mem_valid = ($urandom_range(0, 99) < 60);
            mem_address = rnd_addr();
            mem_data = {$urandom, $urandom};
         end
         hold = ($urandom_range(0, 99) < 15);
         reserve_valid = ($urandom_range(0, 99) < 40);
         reserve_address = rnd_addr();
         read_address_1 = rnd_addr();
         read_address_2 = rnd_addr();
         #1;
         a_acc = alu_valid && alu_ready;
         m_acc = mem_valid && mem_ready;
         tick();
      end

      // Mid-run asynchronous reset, then a single ALU write.
      hold = 1'b0; mem_valid = 1'b0;
      alu_valid = 1'b1; alu_address = 5'd9; alu_data = 64'h99;
      reserve_valid = 1'b1; reserve_address = 5'd4;
      tick();
      alu_valid = 1'b0; reserve_valid = 1'b0;
      chk("pre_reset_write", write, 1);
      chk("pre_reset_busy4", busy_mask[4], 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_write", write, 0);
      chk("async_reset_busy", busy_mask, 0);
      chk("async_reset_address", write_address, 0);
      chk("async_reset_data", write_data, 0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      alu_valid = 1'b1; alu_address = 5'd3; alu_data = 64'h11;
      #1;
      chk("post_reset_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0;
      chk("post_reset_write", write, 1);
      chk("post_reset_address", write_address, 3);
      chk("post_reset_data", write_data, 64'h11);
      tick();
      chk("post_reset_write_once", write, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
